// File: rtl/spi_txn_arbiter_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
//   arb_state_t : arbiter FSM state encoding
//   SPI_W       : width of one SPI command / read word
package spi_arb_pkg;
    localparam int SPI_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_RESP,
        ST_GAP
    } arb_state_t;
endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Requester and SPI-master signal bundle of the arbiter.
//   req/req_cmd            : requester request level and command words
//   gnt/ack                : one-hot grant and one-cycle completion pulse
//   rsp_data/rsp_err       : read word and timeout flag, valid with ack
//   spi_wrt/spi_cmd        : start strobe and command to the SPI master
//   spi_done/spi_rd_data   : SPI master done level and shift register
// slave modport is the arbiter's view; master modport is the environment's.
interface spi_txn_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0][SPI_W-1:0] req_cmd;
    logic [NREQ-1:0]            gnt;
    logic [NREQ-1:0]            ack;
    logic [SPI_W-1:0]           rsp_data;
    logic                       rsp_err;
    logic                       spi_wrt;
    logic [SPI_W-1:0]           spi_cmd;
    logic                       spi_done;
    logic [SPI_W-1:0]           spi_rd_data;

    modport slave (
        input  req, req_cmd, spi_done, spi_rd_data,
        output gnt, ack, rsp_data, rsp_err, spi_wrt, spi_cmd
    );

    modport master (
        output req, req_cmd, spi_done, spi_rd_data,
        input  gnt, ack, rsp_data, rsp_err, spi_wrt, spi_cmd
    );
endinterface

// File: rtl/spi_txn_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req     : request vector
//   ptr     : highest-priority index this round
//   win     : one-hot winner (zero when no request)
//   win_idx : binary index of the winner
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win,
    output logic [$clog2(NREQ)-1:0] win_idx
);
    int p;

    // Walk from the lowest-priority slot up to ptr so the last hit, which
    // is the one closest to ptr, ends up as the winner.
    always_comb begin
        win     = '0;
        win_idx = '0;
        p       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            p = int'(ptr) + k;
            if (p >= NREQ) p = p - NREQ;
            if (req[p]) begin
                win     = '0;
                win[p]  = 1'b1;
                win_idx = ($clog2(NREQ))'(p);
            end
        end
    end
endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one 16-bit SPI master between NREQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester + SPI master signals (slave modport)
// Completion is the rising edge of spi_done; a watchdog turns a missing
// edge into an error response after TIMEOUT_CYC cycles in BUSY.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_txn_arbiter_if.slave bus
);
    localparam int IW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT_CYC);

    arb_state_t       state, state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gnt_idx;
    logic [NREQ-1:0]  gnt_q;
    logic [SPI_W-1:0] cmd_q;
    logic [SPI_W-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic             done_q;
    logic [7:0]       gap_cnt;
    logic [WDW-1:0]   wd_cnt;

    logic [NREQ-1:0]  win;
    logic [IW-1:0]    win_idx;
    logic             any_req;
    logic             done_rise;
    logic             wd_exp;
    logic             gap_end;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    assign any_req   = |bus.req;
    // done is a level held from the previous transaction; only a fresh
    // rising edge counts as completion.
    assign done_rise = bus.spi_done & ~done_q;
    assign wd_exp    = (int'(wd_cnt) >= TIMEOUT_CYC - 1);
    assign gap_end   = (int'(gap_cnt) >= GAP_CYC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_BUSY;
            ST_BUSY:  if (done_rise || wd_exp) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (gap_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            gnt_idx    <= '0;
            gnt_q      <= '0;
            cmd_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            done_q     <= 1'b1;  // no false edge if done is already high
            gap_cnt    <= '0;
            wd_cnt     <= '0;
        end else begin
            done_q <= bus.spi_done;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_q   <= win;
                        gnt_idx <= win_idx;
                        cmd_q   <= bus.req_cmd[win_idx];
                    end
                end
                ST_ISSUE: wd_cnt <= '0;
                ST_BUSY: begin
                    // completion takes precedence over a same-cycle timeout
                    if (done_rise) begin
                        rsp_data_q <= bus.spi_rd_data;
                        rsp_err_q  <= 1'b0;
                    end else if (wd_exp) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    gnt_q   <= '0;
                    gap_cnt <= '0;
                    ptr     <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                end
                ST_GAP:  gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ack      = (state == ST_RESP) ? gnt_q : '0;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;
    assign bus.spi_wrt  = (state == ST_ISSUE);
    assign bus.spi_cmd  = cmd_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
module tb_spi_txn_arbiter;
    import spi_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int GAP     = 8;
    localparam int TO      = 2048;
    localparam int MLAT    = 20;         // SPI model: done rises MLAT+1 cycles after wrt
    localparam int ACK_LAT = MLAT + 2;   // wrt cycle -> ack cycle for a normal completion
    localparam int TO_LAT  = TO + 1;     // wrt cycle -> ack cycle for a timeout

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    spi_txn_arbiter_if #(.NREQ(NREQ)) bus ();

    spi_txn_arbiter #(.NREQ(NREQ), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ack_cnt = 0;
    int   wrt_cnt = 0;
    int   last_wrt_cyc = 0;
    bit   prev_wrt = 0;
    bit   gap_exact = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_chk++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // ---------------- SPI master model (loopback slave) ----------------
    int          lat  = MLAT;
    int          hold = 0;      // cycles done stays stale-high after wrt
    bit          hang = 0;      // never complete
    logic        busy;
    int          mcnt;
    logic [15:0] shreg;
    int          ss_rise_cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy            <= 1'b0;
            mcnt            <= 0;
            shreg           <= '0;
            bus.spi_done    <= 1'b0;
            bus.spi_rd_data <= '0;
            ss_rise_cyc     <= -1;
        end else if (bus.spi_wrt) begin
            busy            <= 1'b1;
            mcnt            <= 0;
            shreg           <= bus.spi_cmd;
            bus.spi_rd_data <= ~bus.spi_cmd;  // garbage while shifting
            if (hold == 0) bus.spi_done <= 1'b0;
            ss_rise_cyc     <= -1;
        end else if (busy) begin
            if (hold > 0 && mcnt == hold - 1) bus.spi_done <= 1'b0;
            if (!hang && mcnt == lat - 1) begin
                busy            <= 1'b0;
                bus.spi_done    <= 1'b1;
                bus.spi_rd_data <= shreg;
                ss_rise_cyc     <= cyc;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        int   ss_high;
        if (rst_n) begin
            if (bus.spi_wrt) begin
                check("wrt_single_cycle", {31'd0, prev_wrt}, 32'd0);
                wrt_cnt++;
                last_wrt_cyc = cyc;
                if (ss_rise_cyc >= 0) begin
                    // SS_n high from the done cycle through the wrt cycle
                    ss_high = cyc - ss_rise_cyc - 1;
                    if (gap_exact) check("ss_high_exact", ss_high, GAP + 3);
                    else           check("ss_high_min", {31'd0, ss_high >= GAP}, 32'd1);
                end
            end
            prev_wrt = bus.spi_wrt;
            if (|bus.ack) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack %b, expected none", bus.ack);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_onehot", {28'd0, bus.ack}, 32'd1 << e.idx);
                    check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, e.data});
                    check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                    check("ack_latency", cyc - last_wrt_cyc, e.lat);
                end
            end
        end else begin
            prev_wrt = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input int idx, input logic [15:0] data, input logic err, input int l);
        exp_t e;
        e.idx = idx; e.data = data; e.err = err; e.lat = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_acks(input int target, input int budget, input string name);
        int n = 0;
        while (ack_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (ack_cnt < target) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: wait expired, acks %0d, expected %0d", name, ack_cnt, target);
        end
    endtask

    task automatic wait_wrt(input int target, input int budget, input string name);
        int n = 0;
        while (wrt_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (wrt_cnt < target) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: wait expired, wrt %0d, expected %0d", name, wrt_cnt, target);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.req_cmd = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", {28'd0, bus.gnt}, 32'd0);
        check("rst_ack", {28'd0, bus.ack}, 32'd0);
        check("rst_wrt", {31'd0, bus.spi_wrt}, 32'd0);
        check("rst_cmd", {16'd0, bus.spi_cmd}, 32'd0);
        check("rst_data", {16'd0, bus.rsp_data}, 32'd0);
        check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("idle_gnt", {28'd0, bus.gnt}, 32'd0);

        // single request: grant and strobe one cycle after req
        bus.req_cmd[0] = 16'hA5C3;
        bus.req[0]     = 1'b1;
        push(0, 16'hA5C3, 1'b0, ACK_LAT);
        @(negedge clk); #1;
        check("single_gnt", {28'd0, bus.gnt}, 32'h1);
        check("single_wrt", {31'd0, bus.spi_wrt}, 32'd1);
        check("single_cmd", {16'd0, bus.spi_cmd}, 32'hA5C3);
        wait_acks(1, 200, "single_ack");
        bus.req[0] = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("single_wrt_count", wrt_cnt, 1);

        // contention from reset: 0,1,2,3 then 0 again
        rst_n       = 1'b0;
        bus.req_cmd = {16'h4303, 16'h3202, 16'h2101, 16'h1000};
        bus.req     = 4'b1111;
        push(0, 16'h1000, 1'b0, ACK_LAT);
        push(1, 16'h2101, 1'b0, ACK_LAT);
        push(2, 16'h3202, 1'b0, ACK_LAT);
        push(3, 16'h4303, 1'b0, ACK_LAT);
        push(0, 16'h1000, 1'b0, ACK_LAT);
        gap_exact = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        wait_acks(6, 400, "contention_acks");
        bus.req   = '0;
        gap_exact = 1'b0;
        repeat (15) @(negedge clk);

        // fairness: ptr is 1; req0 held, req2 arrives mid-transaction
        bus.req_cmd[0] = 16'h0C0C;
        bus.req_cmd[2] = 16'h2A2A;
        bus.req[0]     = 1'b1;
        push(0, 16'h0C0C, 1'b0, ACK_LAT);
        push(2, 16'h2A2A, 1'b0, ACK_LAT);
        push(0, 16'h0C0C, 1'b0, ACK_LAT);
        wait_wrt(wrt_cnt + 1, 50, "fair_wrt");
        repeat (5) @(negedge clk);
        #1;
        bus.req[2] = 1'b1;
        wait_acks(8, 200, "fair_ack2");
        bus.req[2] = 1'b0;
        wait_acks(9, 200, "fair_ack3");
        bus.req[0] = 1'b0;
        repeat (15) @(negedge clk);

        // timeout, then a normal transaction
        hang           = 1'b1;
        bus.req_cmd[3] = 16'hBEEF;
        bus.req[3]     = 1'b1;
        push(3, 16'h0000, 1'b1, TO_LAT);
        wait_acks(10, TO + 200, "timeout_ack");
        bus.req[3]     = 1'b0;
        hang           = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        bus.req_cmd[1] = 16'h0F0F;
        bus.req[1]     = 1'b1;
        push(1, 16'h0F0F, 1'b0, ACK_LAT);
        wait_acks(11, 200, "post_timeout_ack");
        bus.req[1] = 1'b0;
        repeat (15) @(negedge clk);

        // reset while BUSY: no ack for the aborted transfer
        #1;
        bus.req_cmd[1] = 16'h5555;
        bus.req[1]     = 1'b1;
        wait_wrt(wrt_cnt + 1, 50, "rstbusy_wrt");
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstbusy_gnt", {28'd0, bus.gnt}, 32'd0);
        check("rstbusy_ack", {28'd0, bus.ack}, 32'd0);
        check("rstbusy_wrt", {31'd0, bus.spi_wrt}, 32'd0);
        bus.req[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("rstbusy_no_ack", ack_cnt, 11);
        bus.req_cmd[1] = 16'h1234;
        bus.req[1]     = 1'b1;
        push(1, 16'h1234, 1'b0, ACK_LAT);
        wait_acks(12, 200, "post_reset_ack");
        bus.req[1] = 1'b0;
        repeat (15) @(negedge clk);

        // stale done: done stays high a few cycles after wrt
        #1;
        hold           = 4;
        bus.req_cmd[2] = 16'h00FF;
        bus.req[2]     = 1'b1;
        push(2, 16'h00FF, 1'b0, ACK_LAT);
        wait_acks(13, 200, "stale_ack");
        bus.req[2] = 1'b0;
        hold       = 0;
        repeat (20) @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin transaction arbiter that shares one 16-bit SPI master (`SPI_mstr16`) between up to `NREQ` on-chip requesters. It accepts a command word per requester, grants the master to one at a time, drives the master's `wrt`/`cmd` strobe, and detects transaction completion from `done`. It then returns the 16-bit read word with a one-cycle acknowledge. A watchdog aborts transactions whose completion is never seen, so a hung SPI master cannot lock out the requesters.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `GAP_CYC`, 8: idle cycles enforced between consecutive SPI transactions, so SS_n high time is at least this value. Legal range 0..255.
- `TIMEOUT_CYC`, 2048: cycles allowed in BUSY before abort. Must exceed the worst-case SPI transaction length, which is about 600 clk.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, NREQ: per-requester request level.
- `req_cmd`, input, 16*NREQ: command words, requester i at bits [16i+15:16i].
- `gnt`, output, NREQ: one-hot, requester currently owning the master.
- `ack`, output, NREQ: one-hot, one-cycle completion pulse.
- `rsp_data`, output, 16: read word; valid while any `ack` bit is high.
- `rsp_err`, output, 1: qualifies `ack`; 1 means the transaction timed out.
- `spi_wrt`, output, 1: one-cycle start strobe to the master.
- `spi_cmd`, output, 16: command to the master; stable from the `spi_wrt` cycle until completion.
- `spi_done`, input, 1: master done level.
- `spi_rd_data`, input, 16: master shift register contents.

## Operation
- States:
  - IDLE
  - ISSUE
  - BUSY
  - RESP
  - GAP
- **IDLE:** if any `req` is set, select the winner by round-robin, starting at `ptr`. Register `gnt` as one-hot and `cmd_q` as the winner's `req_cmd`, then go to ISSUE.
- **ISSUE:** assert `spi_wrt` for exactly one cycle with `spi_cmd = cmd_q`. Clear the watchdog counter, then go to BUSY.
- **BUSY:**
  - Completion is the rising edge of `spi_done`, i.e. `spi_done` is 1 and `done_q` is 0, where `done_q` is `spi_done` registered.
  - On the edge: capture `spi_rd_data` into `rsp_data`, set `rsp_err` to 0, and go to RESP.
  - If the watchdog reaches `TIMEOUT_CYC-1` first: set `rsp_data` to 16'h0000, set `rsp_err` to 1, and go to RESP.
  - If both happen in the same cycle, completion wins.
- **RESP:** `ack` equals `gnt` for one cycle. Set `ptr` to the granted index + 1, modulo NREQ. Clear `gnt`, then go to GAP.
- **GAP:** count `GAP_CYC` cycles, then go to IDLE. With `GAP_CYC` = 0, go straight to IDLE.
- `spi_done` is a level that stays high from the previous transaction. The arbiter therefore never treats a level as completion, only the edge.
- Requester rules:
  - Hold `req` and `req_cmd` stable until `ack`.
  - `req_cmd` is sampled only in the IDLE grant cycle.
  - A requester still holding `req` after its `ack` is treated as a new request, ranked lowest priority by `ptr`.
- Dropping `req` while granted has no effect. The transaction completes and `ack` still pulses.
- With a single requester continuously requesting, it is served back-to-back, separated by the GAP state.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `gnt` = 0, `ack` = 0, `rsp_data` = 0, `rsp_err` = 0, `spi_wrt` = 0, `spi_cmd` = 0, `done_q` = 1, counters = 0.
  - Initialising `done_q` to 1 suppresses a false edge after reset.
- `req` rising at cycle 0, with the arbiter in IDLE:
  - `gnt` is valid at cycle 1, in ISSUE.
  - `spi_wrt` is high during cycle 1.
  - The master sees `wrt` at the cycle-1 clock edge.
- Completion edge seen in cycle N gives `ack`/`rsp_data` in cycle N+1.
- The next grant is possible no earlier than cycle N+2+`GAP_CYC`.
- Watchdog: `ack` with `rsp_err` = 1 arrives exactly `TIMEOUT_CYC` + 1 cycles after `spi_wrt`.
- Reset mid-transaction: all outputs return to their reset values immediately, with no `ack` emitted. The SPI master is reset by the same `rst_n`.
- `ptr` wraps from NREQ-1 to 0.

## Structure
- Package `spi_arb_pkg`:
  - `arb_state_t` enum covering IDLE, ISSUE, BUSY, RESP, GAP.
  - `localparam SPI_W = 16`.
- Sub-module `rr_pick`:
  - Combinational round-robin priority selector.
  - Inputs: `req[NREQ]` and `ptr`.
  - Outputs: one-hot `win` and index `win_idx`.
- Top level holds the FSM, the `cmd_q`/`rsp_data` registers, the gap counter, the watchdog counter, and the `done_q` edge detector.

## Test plan
- **Single request:** req0 with cmd 16'hA5C3 and a loopback slave (MISO = MOSI). Expect exactly one `spi_wrt` pulse, then `ack[0]` with `rsp_data` = 16'hA5C3 and `rsp_err` = 0.
- **Contention:** req = 4'b1111 asserted simultaneously from reset. Expect grant order 0, 1, 2, 3, then 0 again. Consecutive SS_n high periods must each be at least `GAP_CYC` cycles.
- **Fairness:** req0 held continuously, req2 asserted mid-transaction of req0. Expect req2 served before req0's second transaction.
- **Timeout:** `spi_done` forced low after `spi_wrt`. Expect `ack` with `rsp_err` = 1 and `rsp_data` = 0 at `spi_wrt` + `TIMEOUT_CYC` + 1. The next request is then served normally.
- **Reset during BUSY:** `rst_n` pulsed low mid-shift. Expect `gnt`, `ack`, and `spi_wrt` at 0 and no spurious `ack` after release. The next req1 with cmd 16'h1234 completes correctly.
- **Stale done:** after a completed transaction, `spi_done` remains high. Confirm the next transaction waits for a new rising edge and does not ack early.
